// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// writeback (src0) and load/CSR writeback (src1). A single registered stage
// drives the register file and holds during rf_stall. The pending write is
// forwarded combinationally to both read ports to cover the write-at-edge gap.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH         = 5,
    parameter int DATA_WIDTH         = 32,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_dest,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_dest,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rf_stall,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_dest,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    input  logic [ADDR_WIDTH-1:0] src_one,
    input  logic [ADDR_WIDTH-1:0] src_two,
    output logic                  fwd_hit_one,
    output logic                  fwd_hit_two,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    // ptr_q: 0 -> src0 has priority on contention, 1 -> src1
    logic                  ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  can_load;
    logic                  grant0, grant1;
    logic [ADDR_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0] sel_data;

    // Arbitration: grants only when the stage can load; reset gates readies
    // so no source sees an acceptance while the block is held in reset.
    always_comb begin
        can_load = reset && !rf_stall;
        grant0   = can_load && req0_valid && (!req1_valid || (ptr_q == 1'b0));
        grant1   = can_load && req1_valid && (!req0_valid || (ptr_q == 1'b1));
        sel_dest = grant1 ? req1_dest : req0_dest;
        sel_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next state of the output stage and priority pointer.
    // A write to index 0 is consumed (ready=1) but never strobed; dest/data
    // then hold, which is harmless because the strobe is low.
    always_comb begin
        ptr_d  = ptr_q;
        we_d   = we_q;
        dest_d = dest_q;
        data_d = data_q;
        if (!rf_stall) begin
            we_d = 1'b0;
            if (grant0 || grant1) begin
                // Pointer moves to the source that lost (or did not ask).
                ptr_d = grant0;
                if (!(ZERO_REG_HARDWIRED && (sel_dest == '0))) begin
                    we_d   = 1'b1;
                    dest_d = sel_dest;
                    data_d = sel_data;
                end
            end
        end
    end

    // Output stage and pointer registers; reset discards any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= 1'b0;
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_dest         = dest_q;
    assign rf_data_in      = data_q;

    // Forwarding of the pending write; index 0 never hits when hardwired.
    always_comb begin
        fwd_hit_one = we_q && (dest_q == src_one) &&
                      !(ZERO_REG_HARDWIRED && (src_one == '0));
        fwd_hit_two = we_q && (dest_q == src_two) &&
                      !(ZERO_REG_HARDWIRED && (src_two == '0));
        fwd_data    = data_q;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: a small round-robin model predicts
// readies and a scoreboard queue holds the write expected at the output stage.
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_dest, req1_dest, rf_dest, src_one, src_two;
    logic [DW-1:0] req0_data, req1_data, rf_data_in, fwd_data;
    logic          rf_stall, rf_write_enable, fwd_hit_one, fwd_hit_two;

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_dest(req0_dest), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dest(req1_dest), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_stall(rf_stall), .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_data_in(rf_data_in),
        .src_one(src_one), .src_two(src_two),
        .fwd_hit_one(fwd_hit_one), .fwd_hit_two(fwd_hit_two), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wr_t;

    wr_t  sb[$];
    logic m_ptr, m_we, e_r0, e_r1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive one cycle of inputs (called just after a rising edge) and predict readies.
    task automatic apply(input logic v0, input logic [AW-1:0] d0, input logic [DW-1:0] x0,
                         input logic v1, input logic [AW-1:0] d1, input logic [DW-1:0] x1,
                         input logic st);
        req0_valid = v0; req0_dest = d0; req0_data = x0;
        req1_valid = v1; req1_dest = d1; req1_data = x1;
        rf_stall   = st;
        e_r0 = reset && !st && v0 && (!v1 || !m_ptr);
        e_r1 = reset && !st && v1 && (!v0 || m_ptr);
        #1;
    endtask

    // Advance one clock and update the model: commit the pending write on a
    // non-stall edge and queue the newly granted one.
    task automatic edge_step();
        @(posedge clk);
        if (reset && !rf_stall) begin
            if (m_we && sb.size() > 0) void'(sb.pop_front());
            m_we = 1'b0;
            if (e_r0) begin
                m_ptr = 1'b1;
                if (req0_dest != '0) begin sb.push_back('{dest: req0_dest, data: req0_data}); m_we = 1'b1; end
            end else if (e_r1) begin
                m_ptr = 1'b0;
                if (req1_dest != '0) begin sb.push_back('{dest: req1_dest, data: req1_data}); m_we = 1'b1; end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        m_ptr = 1'b0; m_we = 1'b0; sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; src_one = 3; src_two = 0;
        apply(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        m_ptr = 1'b0; m_we = 1'b0; sb.delete();
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b want 0/0", req0_ready, req1_ready);
        end
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_dest !== '0 || rf_data_in !== '0 || fwd_hit_one !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got we=%b dest=%0d data=%h hit=%b want 0 0 0 0",
                               rf_write_enable, rf_dest, rf_data_in, fwd_hit_one);
        end
        reset = 1'b1;
        apply(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        n_checks++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_ready: got %b want 1", req0_ready); end
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b1 || rf_dest !== 5'd3 || rf_data_in !== 32'hDEADBEEF || fwd_hit_one !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_write: got we=%b dest=%0d data=%h hit=%b want 1 3 deadbeef 1",
                               rf_write_enable, rf_dest, rf_data_in, fwd_hit_one);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] ed;
        logic [DW-1:0] ex;
        do_reset();
        src_one = 5; src_two = 6;
        for (int i = 0; i < 4; i++) begin
            apply(1, 5, 32'h11, 1, 6, 32'h22, 0);
            n_checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got %b/%b want %b/%b",
                                   i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            edge_step();
            ed = (i % 2 == 0) ? 5'd5 : 5'd6;
            ex = (i % 2 == 0) ? 32'h11 : 32'h22;
            n_checks++;
            if (rf_write_enable !== 1'b1 || rf_dest !== ed || rf_data_in !== ex ||
                fwd_hit_one !== (ed == 5) || fwd_hit_two !== (ed == 6) || fwd_data !== ex) begin
                n_fail++; $display("FAIL contention_write[%0d]: got we=%b dest=%0d data=%h hits=%b%b want 1 %0d %h",
                                   i, rf_write_enable, rf_dest, rf_data_in, fwd_hit_one, fwd_hit_two, ed, ex);
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_dest !== 5'd6 || rf_data_in !== 32'h22) begin
            n_fail++; $display("FAIL contention_idle: got we=%b dest=%0d data=%h want 0 6 22",
                               rf_write_enable, rf_dest, rf_data_in);
        end
    endtask

    task automatic test_stall();
        do_reset();
        src_one = 7; src_two = 8;
        apply(1, 7, 32'h55, 0, 0, 0, 0);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 10, 32'h66, 1);
            n_checks++;
            if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready[%0d]: got %b/%b want 0/0", i, req0_ready, req1_ready);
            end
            edge_step();
            n_checks++;
            if (rf_write_enable !== 1'b1 || rf_dest !== 5'd7 || rf_data_in !== 32'h55 ||
                fwd_hit_one !== 1'b1 || fwd_hit_two !== 1'b0 || fwd_data !== 32'h55) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got we=%b dest=%0d data=%h hits=%b%b want 1 7 55 10",
                                   i, rf_write_enable, rf_dest, rf_data_in, fwd_hit_one, fwd_hit_two);
            end
        end
        apply(0, 0, 0, 1, 10, 32'h66, 0);
        n_checks++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", req1_ready); end
        edge_step();
        n_checks++;
        if (sb.size() != 1 || rf_write_enable !== 1'b1 || rf_dest !== sb[0].dest || rf_data_in !== sb[0].data ||
            rf_dest !== 5'd10 || fwd_hit_one !== 1'b0) begin
            n_fail++; $display("FAIL stall_release_write: got we=%b dest=%0d data=%h want 1 10 66 (sb=%0d)",
                               rf_write_enable, rf_dest, rf_data_in, sb.size());
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        src_one = 0; src_two = 2;
        apply(1, 2, 32'h1234, 0, 0, 0, 0);
        edge_step();
        apply(1, 0, 32'hFFFF, 0, 0, 0, 0);
        n_checks++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", req0_ready); end
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b0 || fwd_hit_one !== 1'b0 || fwd_hit_two !== 1'b0) begin
            n_fail++; $display("FAIL zero_write: got we=%b hits=%b%b want 0 00",
                               rf_write_enable, fwd_hit_one, fwd_hit_two);
        end
        // Pointer moved past src0 on the zero-dest grant.
        apply(1, 1, 32'h1, 1, 2, 32'h2, 0);
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ptr: got %b/%b want 0/1", req0_ready, req1_ready);
        end
        edge_step();
    endtask

    task automatic test_same_dest();
        do_reset();
        src_one = 9; src_two = 0;
        apply(1, 9, 32'hA, 1, 9, 32'hB, 0);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL same_dest_first: got %b/%b want 1/0", req0_ready, req1_ready);
        end
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b1 || rf_dest !== 5'd9 || rf_data_in !== 32'hA) begin
            n_fail++; $display("FAIL same_dest_w0: got we=%b dest=%0d data=%h want 1 9 a", rf_write_enable, rf_dest, rf_data_in);
        end
        apply(0, 0, 0, 1, 9, 32'hB, 0);
        n_checks++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL same_dest_second: got %b want 1", req1_ready); end
        edge_step();
        apply(0, 0, 0, 0, 0, 0, 0);
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_dest !== 5'd9 || rf_data_in !== 32'hB) begin
            n_fail++; $display("FAIL same_dest_final: got we=%b dest=%0d data=%h want 0 9 b", rf_write_enable, rf_dest, rf_data_in);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        src_one = 4; src_two = 0;
        apply(1, 4, 32'h44, 0, 0, 0, 0);
        edge_step();
        apply(0, 0, 0, 0, 0, 0, 1);
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b1 || rf_dest !== 5'd4 || fwd_hit_one !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pending: got we=%b dest=%0d hit=%b want 1 4 1", rf_write_enable, rf_dest, fwd_hit_one);
        end
        #1 reset = 1'b0;
        m_ptr = 1'b0; m_we = 1'b0; sb.delete();
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_dest !== '0 || rf_data_in !== '0 || fwd_hit_one !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: got we=%b dest=%0d data=%h hit=%b want 0 0 0 0",
                               rf_write_enable, rf_dest, rf_data_in, fwd_hit_one);
        end
        reset = 1'b1;
        apply(1, 1, 32'h101, 1, 2, 32'h202, 0);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ptr: got %b/%b want 1/0", req0_ready, req1_ready);
        end
        edge_step();
        n_checks++;
        if (rf_write_enable !== 1'b1 || rf_dest !== 5'd1 || rf_data_in !== 32'h101) begin
            n_fail++; $display("FAIL midrst_write: got we=%b dest=%0d data=%h want 1 1 101", rf_write_enable, rf_dest, rf_data_in);
        end
    endtask

    task automatic test_back_to_back();
        logic v0, v1, st;
        logic [AW-1:0] d0, d1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            d0 = AW'($urandom_range(0, 7)); d1 = AW'($urandom_range(0, 7));
            src_one = AW'($urandom_range(0, 7)); src_two = AW'($urandom_range(0, 7));
            apply(v0, d0, $urandom, v1, d1, $urandom, st);
            n_checks++;
            if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b/%b want %b/%b", i, req0_ready, req1_ready, e_r0, e_r1);
            end
            edge_step();
            n_checks++;
            if (rf_write_enable !== m_we) begin
                n_fail++; $display("FAIL b2b_we[%0d]: got %b want %b", i, rf_write_enable, m_we);
            end else if (m_we) begin
                n_checks++;
                if (rf_dest !== sb[0].dest || rf_data_in !== sb[0].data ||
                    fwd_hit_one !== (sb[0].dest == src_one) || fwd_hit_two !== (sb[0].dest == src_two)) begin
                    n_fail++; $display("FAIL b2b_write[%0d]: got dest=%0d data=%h hits=%b%b want %0d %h",
                                       i, rf_dest, rf_data_in, fwd_hit_one, fwd_hit_two, sb[0].dest, sb[0].data);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; rf_stall = 1'b0; src_one = '0; src_two = '0;
        req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
        req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
        m_ptr = 1'b0; m_we = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_contention();
        test_stall();
        test_zero_reg();
        test_same_dest();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
